// File: rtl/seq_pkg.sv
// Shared types and constants for the note sequencer: FSM states and
// the reserved ROM byte values.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    DONE
  } state_t;

  localparam logic [7:0] END_MARK = 8'hFF;
  localparam logic [7:0] REST     = 8'h00;

endpackage

// File: rtl/note_sequencer_if.sv
// Bundle between the sequencer, its control source, the note ROM and the
// tone generator. The master side is the sequencer itself.
interface note_sequencer_if #(
  parameter int ADDR_W = 8
);

  logic              play;
  logic              restart;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        fullnote;
  logic              gate;
  logic              step_strobe;
  logic              song_done;
  logic              playing;

  modport master (
    input  play, restart, loop_en, rom_data,
    output rom_addr, fullnote, gate, step_strobe, song_done, playing
  );

  modport slave (
    output play, restart, loop_en, rom_data,
    input  rom_addr, fullnote, gate, step_strobe, song_done, playing
  );

endinterface

// File: rtl/step_timer.sv
// Per-step tick counter. expire marks the last tick of a step, gap_done the
// end of the articulation gap; gap_next is gap_done as it will read after the
// coming edge, so a registered gate can line up with the tick it describes.
module step_timer #(
  parameter int TICKS_PER_STEP = 4194304,
  parameter int GAP_TICKS      = 262144,
  parameter int TICK_W         = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire,
  output logic gap_done,
  output logic gap_next
);

  logic [TICK_W-1:0] tick;
  logic [TICK_W-1:0] tick_d;

  always_comb begin
    tick_d = tick;
    if (clr) begin
      tick_d = '0;
    end else if (en) begin
      tick_d = expire ? '0 : tick + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
    end else begin
      tick <= tick_d;
    end
  end

  assign expire   = (tick == TICK_W'(TICKS_PER_STEP - 1));
  assign gap_done = (tick >= TICK_W'(GAP_TICKS));
  assign gap_next = (tick_d >= TICK_W'(GAP_TICKS));

endmodule

// File: rtl/note_sequencer.sv
// Tempo-driven note sequencer: fetches notes from a synchronous ROM, holds
// each for one step and drives an articulation gate for the tone generator.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int SONG_LEN       = 256,
  parameter int TICKS_PER_STEP = 4194304,
  parameter int GAP_TICKS      = 262144,
  parameter int TICK_W         = 23
) (
  input logic            clk,
  input logic            rst,
  note_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        note_q;
  logic [7:0]        note_d;
  logic              gate_q;
  logic              gate_d;
  logic              strobe_q;
  logic              strobe_d;
  logic              done_q;
  logic              done_d;
  logic              t_en;
  logic              t_clr;
  logic              expire;
  logic              gap_done;
  logic              gap_next;
  logic              song_end;

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP),
    .GAP_TICKS     (GAP_TICKS),
    .TICK_W        (TICK_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (t_en),
    .clr     (t_clr),
    .expire  (expire),
    .gap_done(gap_done),
    .gap_next(gap_next)
  );

  // Restart overrides everything; song_end funnels both the end marker and
  // the last address into one wrap-or-stop decision.
  always_comb begin
    state_d  = state;
    addr_d   = addr_q;
    note_d   = note_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    t_en     = 1'b0;
    t_clr    = 1'b0;
    song_end = 1'b0;
    if (bus.restart) begin
      addr_d  = '0;
      note_d  = REST;
      t_clr   = 1'b1;
      state_d = bus.play ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          note_d = REST;
          if (bus.play) state_d = FETCH;
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          if (bus.rom_data == END_MARK) begin
            song_end = 1'b1;
          end else begin
            note_d   = bus.rom_data;
            strobe_d = 1'b1;
            t_clr    = 1'b1;
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (bus.play) begin
            if (!expire) begin
              t_en = 1'b1;
            end else if (addr_q == LAST_ADDR) begin
              song_end = 1'b1;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = FETCH;
            end
          end
        end
        DONE: note_d = REST;
        default: state_d = IDLE;
      endcase
      if (song_end) begin
        if (bus.loop_en) begin
          addr_d  = '0;
          state_d = FETCH;
        end else begin
          note_d  = REST;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
    end
  end

  assign gate_d = (state_d == PLAY) && bus.play && (note_d != REST) && gap_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      note_q   <= REST;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      note_q   <= note_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  // The gate may only be open once the gap part of the step has elapsed.
  gate_after_gap_a: assert property (@(posedge clk) disable iff (rst) gate_q |-> gap_done);

  assign bus.rom_addr    = addr_q;
  assign bus.fullnote    = note_q;
  assign bus.gate        = gate_q;
  assign bus.step_strobe = strobe_q;
  assign bus.song_done   = done_q;
  assign bus.playing     = (state == FETCH) || (state == LOAD) || (state == PLAY);

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: directed songs push expected strobe and
// song_done events; a negedge monitor pops and compares them as they appear.
module tb_note_sequencer;
  import seq_pkg::*;

  typedef struct {
    bit   is_done;
    int   note;
    int   addr;
    int   gap;
    int   gates;
  } exp_t;

  logic clk;
  logic rst;
  logic [7:0] rom [4];
  int   checks;
  int   errors;
  int   cyc;
  int   last_cyc;
  int   gate_cnt;
  int   ff_seen;
  exp_t exp_q[$];
  exp_t mon_item;

  note_sequencer_if #(.ADDR_W(8)) bus ();

  note_sequencer #(
    .ADDR_W        (8),
    .SONG_LEN      (4),
    .TICKS_PER_STEP(8),
    .GAP_TICKS     (2),
    .TICK_W        (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.rom_data <= rom[bus.rom_addr[1:0]];
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  function automatic void expect_ev(input bit is_done, input int note, input int addr,
                                    input int gap, input int gates);
    exp_t e;
    e.is_done = is_done;
    e.note    = note;
    e.addr    = addr;
    e.gap     = gap;
    e.gates   = gates;
    exp_q.push_back(e);
  endfunction

  // gap and gates of -1 mean the interval since the previous event is not checked.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fullnote == END_MARK) ff_seen++;
      if (bus.step_strobe || bus.song_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event strobe=%0b done=%0b note=%0h at cycle %0d",
                   bus.step_strobe, bus.song_done, bus.fullnote, cyc);
        end else begin
          mon_item = exp_q.pop_front();
          check_output("event_is_done", int'(bus.song_done), int'(mon_item.is_done));
          check_output("event_strobe", int'(bus.step_strobe), int'(!mon_item.is_done));
          check_output("event_fullnote", int'(bus.fullnote), mon_item.note);
          check_output("event_rom_addr", int'(bus.rom_addr), mon_item.addr);
          if (mon_item.gap >= 0) check_output("event_gap_cycles", cyc - last_cyc, mon_item.gap);
          if (mon_item.gates >= 0) check_output("gate_cycles_prev_step", gate_cnt, mon_item.gates);
        end
        last_cyc = cyc;
        gate_cnt = int'(bus.gate);
      end else begin
        gate_cnt += int'(bus.gate);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reset_dut();
    rst         = 1'b1;
    bus.play    = 1'b0;
    bus.restart = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic stop_song();
    bus.restart = 1'b1;
    bus.play    = 1'b0;
    tick(1);
    bus.restart = 1'b0;
    check_output("stopped_playing", int'(bus.playing), 0);
    check_output("stopped_fullnote", int'(bus.fullnote), 0);
  endtask

  task automatic apply_stimulus();
    rom[0] = 8'h21; rom[1] = 8'h00; rom[2] = 8'h21; rom[3] = 8'h15;
    bus.loop_en = 1'b0;

    // Reset state
    rst = 1'b1;
    bus.play = 1'b0;
    bus.restart = 1'b0;
    tick(3);
    check_output("reset_fullnote", int'(bus.fullnote), 0);
    check_output("reset_rom_addr", int'(bus.rom_addr), 0);
    check_output("reset_playing", int'(bus.playing), 0);
    check_output("reset_gate", int'(bus.gate), 0);
    rst = 1'b0;
    tick(2);
    check_output("idle_playing", int'(bus.playing), 0);

    // 1: full song, stop at end
    $display("[TB] basic sequence");
    expect_ev(0, 8'h21, 0, -1, -1);
    expect_ev(0, 8'h00, 1, 10, 6);
    expect_ev(0, 8'h21, 2, 10, 0);
    expect_ev(0, 8'h15, 3, 10, 6);
    expect_ev(1, 8'h00, 3, 8, 6);
    bus.play = 1'b1;
    wait_drain("basic", 200);
    tick(2);
    check_output("done_fullnote", int'(bus.fullnote), 0);
    check_output("done_playing", int'(bus.playing), 0);
    check_output("done_gate", int'(bus.gate), 0);

    // 2: loop back to address 0, no song_done
    $display("[TB] loop");
    reset_dut();
    bus.loop_en = 1'b1;
    expect_ev(0, 8'h21, 0, -1, -1);
    expect_ev(0, 8'h00, 1, 10, 6);
    expect_ev(0, 8'h21, 2, 10, 0);
    expect_ev(0, 8'h15, 3, 10, 6);
    expect_ev(0, 8'h21, 0, 10, 6);
    bus.play = 1'b1;
    wait_drain("loop", 200);
    stop_song();
    bus.loop_en = 1'b0;

    // 3: pause at tick 4 of step 0 for 20 cycles
    $display("[TB] pause");
    reset_dut();
    expect_ev(0, 8'h21, 0, -1, -1);
    expect_ev(0, 8'h00, 1, 30, 6);
    bus.play = 1'b1;
    tick(7);
    bus.play = 1'b0;
    tick(10);
    check_output("pause_fullnote", int'(bus.fullnote), 8'h21);
    check_output("pause_gate", int'(bus.gate), 0);
    check_output("pause_playing", int'(bus.playing), 1);
    tick(10);
    bus.play = 1'b1;
    wait_drain("pause", 200);
    stop_song();

    // 4: restart in step 2 at tick 5
    $display("[TB] restart");
    reset_dut();
    expect_ev(0, 8'h21, 0, -1, -1);
    expect_ev(0, 8'h00, 1, 10, 6);
    expect_ev(0, 8'h21, 2, 10, 0);
    expect_ev(0, 8'h21, 0, 8, 4);
    expect_ev(0, 8'h00, 1, 10, 6);
    expect_ev(0, 8'h21, 2, 10, 0);
    expect_ev(0, 8'h15, 3, 10, 6);
    expect_ev(1, 8'h00, 3, 8, 6);
    bus.play = 1'b1;
    tick(28);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    check_output("restart_rom_addr", int'(bus.rom_addr), 0);
    check_output("restart_fullnote", int'(bus.fullnote), 0);
    check_output("restart_strobe", int'(bus.step_strobe), 0);
    check_output("restart_playing", int'(bus.playing), 1);
    wait_drain("restart", 200);

    // 5: end marker at address 1
    $display("[TB] end marker");
    reset_dut();
    rom[1] = END_MARK;
    ff_seen = 0;
    expect_ev(0, 8'h21, 0, -1, -1);
    expect_ev(1, 8'h00, 1, 10, 6);
    bus.play = 1'b1;
    wait_drain("end_marker", 200);
    tick(3);
    check_output("end_marker_never_loaded", ff_seen, 0);
    check_output("end_marker_playing", int'(bus.playing), 0);
    rom[1] = 8'h00;

    // 6: async reset between edges mid-PLAY
    $display("[TB] async reset");
    reset_dut();
    expect_ev(0, 8'h21, 0, -1, -1);
    bus.play = 1'b1;
    tick(6);
    check_output("pre_reset_gate", int'(bus.gate), 1);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_fullnote", int'(bus.fullnote), 0);
    check_output("async_gate", int'(bus.gate), 0);
    check_output("async_playing", int'(bus.playing), 0);
    check_output("async_strobe", int'(bus.step_strobe), 0);
    check_output("async_done", int'(bus.song_done), 0);
    check_output("async_rom_addr", int'(bus.rom_addr), 0);
    check_output("async_queue_drained", exp_q.size(), 0);
    expect_ev(0, 8'h21, 0, -1, -1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_drain("after_reset", 50);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_cyc = 0;
    gate_cnt = 0;
    ff_seen  = 0;
    apply_stimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Tempo-driven note sequencer that sits directly upstream of the square-wave tone generator. It walks a synchronous note ROM address by address and holds each 8-bit fullnote for one step. It produces an articulation gate that lets consecutive identical notes be heard separately. Adds play/pause, restart, loop and an end-of-song marker, so songs are no longer a free-running address counter.

Parameters:
ADDR_W, 8, note ROM address width
SONG_LEN, 256, number of ROM entries played before wrap or stop (1..2^ADDR_W)
TICKS_PER_STEP, 4194304, clk cycles a note is held in PLAY (>= GAP_TICKS+1)
GAP_TICKS, 262144, clk cycles at start of each step during which gate is low
TICK_W, 23, tick counter width (must hold TICKS_PER_STEP-1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause
restart  in  1  single-cycle pulse; rewind to address 0
loop_en  in  1  1 = wrap to address 0 at song end; 0 = stop
rom_addr  out  ADDR_W  registered note ROM address
rom_data  in  8  ROM output, valid exactly one clk after rom_addr changes
fullnote  out  8  current note to tone generator; 0 = rest
gate  out  1  1 = tone may sound
step_strobe  out  1  one-cycle pulse when a new fullnote loads
song_done  out  1  one-cycle pulse on entry to DONE
playing  out  1  1 in FETCH/LOAD/PLAY

Behaviour:
- Reset (async, rst=1) values:
  - state=IDLE, rom_addr=0, tick=0.
  - fullnote=0, gate=0, step_strobe=0, song_done=0, playing=0.
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- IDLE: fullnote=0. If play=1, go to FETCH next cycle.
- FETCH (1 cycle): rom_addr is stable; ROM access is in flight. Go to LOAD.
- LOAD (1 cycle): samples rom_data.
  - rom_data==8'hFF (END_MARK): nothing loads; apply the end-of-song rule.
  - Otherwise: fullnote<=rom_data, step_strobe=1 for this cycle, tick<=0, go to PLAY.
- PLAY:
  - play=1: tick increments each cycle.
  - play=0: tick and fullnote hold, gate=0; state stays PLAY (pause).
  - On tick==TICKS_PER_STEP-1 with play=1:
    - rom_addr==SONG_LEN-1: apply the end-of-song rule.
    - Otherwise: rom_addr<=rom_addr+1, go to FETCH.
- End-of-song rule:
  - loop_en=1: rom_addr<=0, go to FETCH.
  - loop_en=0: go to DONE, fullnote<=0, song_done=1 for one cycle.
- Step period is TICKS_PER_STEP+2 cycles (FETCH+LOAD overhead). fullnote is unchanged through FETCH/LOAD, so the tone is continuous across steps.
- gate is registered and equals (state==PLAY && play && fullnote!=0 && tick>=GAP_TICKS). It is low during FETCH/LOAD, IDLE and DONE.
- DONE: fullnote=0, gate=0. Holds until restart. loop_en rising while in DONE has no effect.
- restart (any state):
  - Same cycle: rom_addr<=0, tick<=0, fullnote<=0.
  - Next state is FETCH if play=1, else IDLE.
  - restart has priority over tick expiry, the end-of-song rule and pause.
- play dropping during FETCH/LOAD: the fetch completes and PLAY is entered paused (tick holds at 0).
- rom_addr wraps only via the rules above; ADDR_W arithmetic never overflows for SONG_LEN <= 2^ADDR_W.
- Reset asserted mid-step: all outputs return to reset values immediately (async); no partial note is emitted after release.

Decomposition:
- Package seq_pkg:
  - state enum {IDLE, FETCH, LOAD, PLAY, DONE}.
  - constants END_MARK=8'hFF and REST=8'h00.
- Sub-module step_timer:
  - Tick counter with en, clr, expire (tick==TICKS_PER_STEP-1) and gap_done (tick>=GAP_TICKS) outputs.
  - Parameterised by TICKS_PER_STEP, GAP_TICKS, TICK_W.
- The FSM and address register stay in note_sequencer.

Test Plan:
(params TICKS_PER_STEP=8, GAP_TICKS=2, SONG_LEN=4, ROM={8'h21,8'h00,8'h21,8'h15})
1. Basic sequence, loop_en=0:
   - Reset, then play=1.
   - fullnote goes 21,00,21,15, each held 10 cycles; step_strobe fires every 10 cycles.
   - gate high 6 cycles per non-rest step and 0 during the 00 step.
   - song_done pulses once, then fullnote=0 and playing=0.
2. Loop: as 1 with loop_en=1 → after 15, rom_addr returns to 0, fullnote=21 again, and song_done never pulses.
3. Pause:
   - Drop play at tick=4 of step 0 for 20 cycles: gate=0 and fullnote=21 hold, tick frozen at 4.
   - On resume, the step ends after 3 more ticks (at tick 7).
4. Restart in step 2 at tick 5 with play=1 → next cycle rom_addr=0 and FETCH; step_strobe with fullnote=21 two cycles later.
5. End marker: ROM[1]=8'hFF, loop_en=0 → after step 0, DONE and a song_done pulse; fullnote never equals FF.
6. Async reset asserted mid-PLAY between clock edges → all outputs 0 before the next edge; after release with play=1, fetch restarts at address 0.
